// File: rtl/booth_mul_if.sv
// booth_mul_if: operand/result valid-ready bus for the Booth multiplier sequencer
interface booth_mul_if #(parameter int N = 32, parameter int TAG_W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_multiplier;
  logic [N-1:0]     in_multiplicand;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   out_product;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, in_multiplier, in_multiplicand, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );
  modport slave (
    input  in_valid, in_multiplier, in_multiplicand, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );
endinterface

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: FIFO-buffered launch/settle/capture sequencer around a combinational Booth array
module booth_mul_sequencer #(
  parameter int N          = 32,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 3,
  parameter int TAG_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  booth_mul_if.slave             bus,
  output logic [N-1:0]           mult_multiplier_o,
  output logic [N-1:0]           mult_multiplicand_o,
  input  logic [2*N-1:0]         mult_product_i,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state, state_n;
  logic [N-1:0] mem_a [DEPTH];
  logic [N-1:0] mem_b [DEPTH];
  logic [TAG_W-1:0] mem_t [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt;
  logic [TAG_W-1:0] tag_r;
  logic out_valid_r;
  logic [2*N-1:0] out_product_r;
  logic [TAG_W-1:0] out_tag_r;
  logic in_ready_w, push, pop, capture, release_w;
  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_product = out_product_r;
  assign bus.out_tag     = out_tag_r;
  assign fifo_count      = count;
  assign busy            = state != IDLE || count != '0;
  always_comb begin
    in_ready_w = count != (AW+1)'(DEPTH);
    push       = bus.in_valid && in_ready_w;
    release_w  = state == HOLD && bus.out_ready;
    pop        = count != '0 && (state == IDLE || release_w);
    capture    = state == SETTLE && cnt == '0;
    state_n    = pop ? SETTLE : capture ? HOLD : release_w ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_multiplier;
      mem_b[wr_ptr] <= bus.in_multiplicand;
      mem_t[wr_ptr] <= bus.in_tag;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      cnt                 <= '0;
      tag_r               <= '0;
      mult_multiplier_o   <= '0;
      mult_multiplicand_o <= '0;
      out_valid_r         <= 1'b0;
      out_product_r       <= '0;
      out_tag_r           <= '0;
    end else begin
      state <= state_n;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr              <= rd_ptr + AW'(1);
        mult_multiplier_o   <= mem_a[rd_ptr];
        mult_multiplicand_o <= mem_b[rd_ptr];
        tag_r               <= mem_t[rd_ptr];
        cnt                 <= CW'(SETTLE_CYC - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        out_valid_r   <= 1'b1;
        out_product_r <= mult_product_i;
        out_tag_r     <= tag_r;
      end else if (release_w) begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: directed self-checking bench with scoreboard for booth_mul_sequencer
module tb_booth_mul_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  booth_mul_if #(.N(32), .TAG_W(4)) bus();
  logic [31:0] mult_a, mult_b;
  logic signed [63:0] mult_p;
  logic busy;
  logic [2:0] fifo_count;
  assign mult_p = $signed(mult_a) * $signed(mult_b);
  booth_mul_sequencer #(.N(32), .DEPTH(4), .SETTLE_CYC(3), .TAG_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .mult_multiplier_o(mult_a),
    .mult_multiplicand_o(mult_b),
    .mult_product_i(mult_p),
    .busy(busy),
    .fifo_count(fifo_count)
  );
  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  typedef struct {logic [31:0] a; logic [31:0] b; logic [3:0] t;} op_t;
  op_t q[$];
  op_t op_new;
  logic signed [63:0] exp_p;
  logic [31:0] ca [3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
  logic [31:0] cb [3] = '{32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
  logic [63:0] ce [3] = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000, 64'h0};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (bus.out_valid) begin
        chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_p = $signed(q[0].a) * $signed(q[0].b);
          chk("sb_product", bus.out_product, exp_p);
          chk("sb_tag", 64'(bus.out_tag), 64'(q[0].t));
          chk("hold_mult_a", 64'(mult_a), 64'(q[0].a));
          chk("hold_mult_b", 64'(mult_b), 64'(q[0].b));
          if (bus.out_ready) begin
            void'(q.pop_front());
            hs_count++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        op_new.a = bus.in_multiplier;
        op_new.b = bus.in_multiplicand;
        op_new.t = bus.in_tag;
        q.push_back(op_new);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_multiplier = a;
    bus.in_multiplicand = b;
    bus.in_tag = t;
    do begin
      acc = bus.in_ready;
      step();
      n++;
    end while (!acc && n < 100);
    bus.in_valid = 1'b0;
    chk("push_accept", 64'(acc), 64'd1);
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    chk("valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask
  task automatic take();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int n, h0;
    bus.in_valid = 1'b0;
    bus.in_multiplier = '0;
    bus.in_multiplicand = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_mult_a", 64'(mult_a), 64'd0);
    chk("rst_product", bus.out_product, 64'd0);
    rst = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_multiplier = 32'd3;
    bus.in_multiplicand = 32'hFFFF_FFFB;
    bus.in_tag = 4'd1;
    step();
    bus.in_valid = 1'b0;
    chk("single_count", 64'(fifo_count), 64'd1);
    chk("single_busy", 64'(busy), 64'd1);
    step();
    step();
    step();
    chk("single_early", 64'(bus.out_valid), 64'd0);
    chk("single_mult_a", 64'(mult_a), 64'd3);
    step();
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_product", bus.out_product, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("single_tag", 64'(bus.out_tag), 64'd1);
    take();
    chk("single_drop", 64'(bus.out_valid), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      push(ca[i], cb[i], 4'(i + 2));
      wait_valid(n);
      chk("corner_product", bus.out_product, ce[i]);
      take();
    end
    for (int i = 0; i < 5; i++) push(32'(i + 1), 32'd10, 4'(i));
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_multiplier = 32'd99;
    bus.in_tag = 4'd5;
    step();
    bus.in_valid = 1'b0;
    chk("full_refuse", 64'(fifo_count), 64'd4);
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_product", bus.out_product, 64'd10);
      chk("stall_tag", 64'(bus.out_tag), 64'd0);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        step();
        wait_valid(n);
        chk("bp_spacing", 64'(n + 1), 64'd4);
      end
      chk("bp_tag", 64'(bus.out_tag), 64'(k));
      chk("bp_product", bus.out_product, 64'((k + 1) * 10));
    end
    step();
    chk("bp_drain_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_drain_busy", 64'(busy), 64'd0);
    bus.out_ready = 1'b0;
    push(32'd1, 32'd2, 4'd10);
    push(32'd3, 32'd4, 4'd11);
    push(32'd5, 32'd6, 4'd12);
    wait_valid(n);
    chk("simul_pre", 64'(fifo_count), 64'd2);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_multiplier = 32'd7;
    bus.in_multiplicand = 32'd8;
    bus.in_tag = 4'd13;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("simul_count", 64'(fifo_count), 64'd2);
    bus.out_ready = 1'b1;
    wait_idle();
    h0 = hs_count;
    for (int i = 0; i < 12; i++) push(32'(i * 3 - 7), 32'(1000 + i * 17), 4'(i));
    wait_idle();
    chk("wrap_results", 64'(hs_count - h0), 64'd12);
    bus.out_ready = 1'b0;
    push(32'd11, 32'd12, 4'd1);
    push(32'd13, 32'd14, 4'd2);
    push(32'd15, 32'd16, 4'd3);
    chk("mid_count", 64'(fifo_count), 64'd2);
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_product", bus.out_product, 64'd0);
    chk("arst_mult_a", 64'(mult_a), 64'd0);
    chk("arst_mult_b", 64'(mult_b), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no_stale", 64'(bus.out_valid), 64'd0);
    end
    push(32'd7, 32'd6, 4'd9);
    wait_valid(n);
    chk("post_rst_product", bus.out_product, 64'd42);
    chk("post_rst_tag", 64'(bus.out_tag), 64'd9);
    take();
    chk("post_rst_drop", 64'(bus.out_valid), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
